// File: rtl/booth_seq_multiplier.sv
// rtl/booth_seq_multiplier.sv - radix-2 sequential Booth multiplier with start/done handshake
module booth_seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     multiplicand_i,
    input  logic [WIDTH-1:0]     multiplier_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH:0]  ONE_A      = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [CW-1:0]   COUNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   COUNT_INIT = CW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [WIDTH:0]       a_q;
    logic [WIDTH:0]       m_q;
    logic [WIDTH-1:0]     q_q;
    logic                 q1_q;
    logic [CW-1:0]        count_q;
    logic [2*WIDTH-1:0]   product_q;

    logic [WIDTH:0]       sum_d;
    logic [WIDTH:0]       a_d;
    logic [WIDTH-1:0]     q_d;
    logic                 q1_d;

    // One Booth iteration: add/subtract M by the {Q0,Q_1} pair, then arithmetic shift of {A,Q,Q_1}.
    // A carries an extra sign bit, so A-M with M = -2^(WIDTH-1) still fits.
    always_comb begin
        sum_d = a_q;
        unique case ({q_q[0], q1_q})
            2'b01:   sum_d = a_q + m_q;
            2'b10:   sum_d = a_q + ~m_q + ONE_A;
            default: sum_d = a_q;
        endcase
        a_d  = {sum_d[WIDTH], sum_d[WIDTH:1]};
        q_d  = {sum_d[0], q_q[WIDTH-1:1]};
        q1_d = q_q[0];
    end

    // Control FSM and datapath registers; product latched on the last iteration and held after.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            m_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        a_q     <= '0;
                        q_q     <= multiplier_i;
                        q1_q    <= 1'b0;
                        m_q     <= {multiplicand_i[WIDTH-1], multiplicand_i};
                        count_q <= COUNT_INIT;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_q     <= a_d;
                    q_q     <= q_d;
                    q1_q    <= q1_d;
                    count_q <= count_q - COUNT_ONE;
                    if (count_q == COUNT_ONE) begin
                        product_q <= {a_d[WIDTH-1:0], q_d};
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o    = (state_q == S_RUN);
    assign done_o    = (state_q == S_DONE);
    assign product_o = product_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb/tb_booth_seq_multiplier.sv - self-checking bench for booth_seq_multiplier
module tb_booth_seq_multiplier;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   mc;
    logic [W-1:0]   mp;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int errors = 0;
    int checks = 0;

    booth_seq_multiplier #(.WIDTH(W)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .multiplicand_i (mc),
        .multiplier_i   (mp),
        .busy_o         (busy),
        .done_o         (done),
        .product_o      (product)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_product(input logic [7:0] m, input logic [7:0] q);
        int mi;
        int qi;
        int r;
        mi = $signed(m);
        qi = $signed(q);
        r  = mi * qi;
        return r[15:0];
    endfunction

    // Waits for idle, issues one operation, and reports the observed result and timing.
    // lat is the number of edges from accept to Done (-1 on timeout).
    task automatic run_op(input logic [7:0] m, input logic [7:0] q,
                          output logic [15:0] prod, output int lat,
                          output int busy_cyc, output int excl);
        int n;
        excl = 0;
        busy_cyc = 0;
        lat = -1;
        prod = 'x;
        n = 0;
        @(negedge clk);
        while ((busy || done) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy || done) return;
        start = 1'b1;
        mc = m;
        mp = q;
        @(posedge clk);
        #1;
        start = 1'b0;
        mc = 8'($urandom);
        mp = 8'($urandom);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (busy && done) excl++;
            if (done) begin
                lat = k;
                prod = product;
                return;
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        mc = '0;
        mp = '0;
        #12;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b product=%h expected 0 0 0000", busy, done, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
            errors++;
            $display("FAIL after_release_idle: busy=%b done=%b product=%h expected 0 0 0000", busy, done, product);
        end
    endtask

    task automatic test_basic;
        logic [15:0] p;
        int lat, bc, ex;
        run_op(8'd3, 8'd5, p, lat, bc, ex);
        checks++;
        if (p !== 16'h000F) begin
            errors++;
            $display("FAIL basic_product: got %h expected 000f", p);
        end
        checks++;
        if (lat !== W) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected %0d", lat, W);
        end
        checks++;
        if (bc !== W || ex !== 0) begin
            errors++;
            $display("FAIL basic_busy: busy cycles %0d overlap %0d expected %0d 0", bc, ex, W);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || product !== 16'h000F) begin
            errors++;
            $display("FAIL basic_done_drop: done=%b product=%h expected 0 000f", done, product);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (product !== 16'h000F || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold: product=%h busy=%b expected 000f 0", product, busy);
        end
    endtask

    task automatic test_signed_and_corners;
        logic [7:0]  tm [8];
        logic [7:0]  tq [8];
        logic [15:0] te [8];
        logic [15:0] p;
        int lat, bc, ex;
        tm[0] = 8'hF9; tq[0] = 8'd6;  te[0] = 16'hFFD6;
        tm[1] = 8'd6;  tq[1] = 8'hF9; te[1] = 16'hFFD6;
        tm[2] = 8'h80; tq[2] = 8'h80; te[2] = 16'h4000;
        tm[3] = 8'h7F; tq[3] = 8'h80; te[3] = 16'hC080;
        tm[4] = 8'h00; tq[4] = 8'hFF; te[4] = 16'h0000;
        tm[5] = 8'hFF; tq[5] = 8'hFF; te[5] = 16'h0001;
        tm[6] = 8'h80; tq[6] = 8'h7F; te[6] = 16'hC080;
        tm[7] = 8'h7F; tq[7] = 8'h7F; te[7] = 16'h3F01;
        for (int i = 0; i < 8; i++) begin
            run_op(tm[i], tq[i], p, lat, bc, ex);
            checks++;
            if (p !== te[i] || lat !== W) begin
                errors++;
                $display("FAIL corner_%0d: M=%h Q=%h got %h lat %0d expected %h lat %0d",
                         i, tm[i], tq[i], p, lat, te[i], W);
            end
        end
    endtask

    task automatic test_start_ignored;
        int n, lat;
        n = 0;
        @(negedge clk);
        while ((busy || done) && n < 50) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1;
        mc = 8'd3;
        mp = 8'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 3) begin
                start = 1'b1;
                mc = 8'h80;
                mp = 8'h7F;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = k;
                break;
            end
            @(posedge clk);
        end
        checks++;
        if (lat !== W || product !== 16'h000F) begin
            errors++;
            $display("FAIL midrun_start: lat %0d product %h expected %0d 000f", lat, product, W);
        end
        start = 1'b1;
        mc = 8'd2;
        mp = 8'd3;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL held_start_idle_gap: busy=%b done=%b expected 0 0", busy, done);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL held_start_accept: busy=%b expected 1", busy);
        end
        start = 1'b0;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (lat !== W || product !== 16'h0006) begin
            errors++;
            $display("FAIL held_start_result: lat %0d product %h expected %0d 0006", lat, product, W);
        end
    endtask

    task automatic test_async_reset;
        logic [15:0] p;
        int n, lat, bc, ex;
        n = 0;
        @(negedge clk);
        while ((busy || done) && n < 50) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1;
        mc = 8'd3;
        mp = 8'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || product !== 16'h0006) begin
            errors++;
            $display("FAIL pre_reset_state: busy=%b product=%h expected 1 0006", busy, product);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b product=%h expected 0 0 0000", busy, done, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'd3, 8'd5, p, lat, bc, ex);
        checks++;
        if (p !== 16'h000F || lat !== W) begin
            errors++;
            $display("FAIL post_reset_op: product %h lat %0d expected 000f %0d", p, lat, W);
        end
    endtask

    task automatic test_random;
        logic [7:0]  m, q;
        logic [15:0] p, e;
        int lat, bc, ex;
        for (int i = 0; i < 1000; i++) begin
            m = 8'($urandom);
            q = 8'($urandom);
            if (i % 50 == 0) m = 8'h80;
            if (i % 70 == 0) q = 8'h80;
            e = ref_product(m, q);
            run_op(m, q, p, lat, bc, ex);
            checks++;
            if (p !== e) begin
                errors++;
                $display("FAIL rand_product_%0d: M=%h Q=%h got %h expected %h", i, m, q, p, e);
            end
            checks++;
            if (lat !== W || bc !== W) begin
                errors++;
                $display("FAIL rand_timing_%0d: lat %0d busy %0d expected %0d %0d", i, lat, bc, W, W);
            end
            checks++;
            if (ex !== 0) begin
                errors++;
                $display("FAIL rand_exclusive_%0d: overlap cycles %0d expected 0", i, ex);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || product !== e) begin
                errors++;
                $display("FAIL rand_done_pulse_%0d: done=%b busy=%b product=%h expected 0 0 %h",
                         i, done, busy, product, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed_and_corners();
        test_start_ignored();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/booth_seq_multiplier.md
# booth_seq_multiplier

Radix-2 sequential Booth multiplier with its controlling state machine. It multiplies two signed two's-complement operands over WIDTH iterations, sharing a single (WIDTH+1)-bit add/subtract datapath across all iterations. It sits beside the combinational adder cells of the arithmetic unit and is started and polled by a simple Start/Done handshake.

## Interface
- WIDTH, 8: operand width in bits (≥2); product is 2*WIDTH bits.
- Clk  input  1  single clock; all state updates on rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only in IDLE.
- Multiplicand  input  WIDTH  signed M; captured on accepted Start.
- Multiplier  input  WIDTH  signed Q; captured on accepted Start.
- Busy  output  1  high while state is RUN.
- Done  output  1  one-cycle pulse; Product valid from this cycle.
- Product  output  2*WIDTH  signed result; held until next completion.

## Operation
- Internal registers: A (WIDTH+1 bits, sign-extended accumulator), Q (WIDTH), Q_1 (1), M (WIDTH+1, sign-extended Multiplicand), Count (ceil(log2(WIDTH+1)) bits).
- States: IDLE, RUN, DONE (Moore FSM).
- IDLE: if Start=1 at an edge -> load A=0, Q=Multiplier, Q_1=0, M=sext(Multiplicand), Count=WIDTH; go RUN. Otherwise hold all state.
- RUN, each edge: select by {Q[0],Q_1}: 00/11 -> A unchanged; 01 -> A+M; 10 -> A−M (A + ~M + 1); then arithmetic shift right of {A,Q,Q_1} by one (A MSB replicated); Count−1.
- RUN, edge where Count=1: perform final iteration, load Product = {A[WIDTH−1:0],Q} of the shifted result, go DONE.
- DONE: Done=1 for this cycle; next edge -> IDLE unconditionally.
- Arithmetic: A is WIDTH+1 bits so A±M never overflows, including M = −2^(WIDTH−1); add/sub carry-out discarded. Product is exact for all operand pairs.
- Start while RUN or DONE: ignored; operands not re-sampled.
- Start held high continuously: new operation accepted on the first edge in IDLE (one idle cycle between operations).
- Operand inputs may change freely after the accepting edge.

## Timing
- Reset (Rst_n=0, asynchronous): state=IDLE, Busy=0, Done=0, Product=0, A=Q=M=Q_1=Count=0. Takes effect immediately, including mid-RUN; partial result discarded, Product cleared.
- Reset release: first edge with Rst_n=1 operates normally (synchronizer is external).
- Accept edge = E0. Busy=1 from after E0 through the edge E(WIDTH). Product updated and Done=1 after edge E(WIDTH); Done drops after E(WIDTH+1).
- Latency Start-accept to Done: WIDTH edges; throughput one result per WIDTH+2 cycles.
- Busy and Done never high simultaneously; Done never high for more than one cycle.
- All outputs registered or decoded directly from state; no combinational path from inputs to outputs.

## Test plan
- Reset then WIDTH=8, M=3, Q=5, Start one cycle -> Busy high 8 cycles, Done pulse exactly 8 edges after accept, Product=0x000F, Product holds 0x000F afterwards.
- M=−7 (0xF9), Q=6 -> Product=0xFFD6 (−42); M=6, Q=−7 -> same 0xFFD6.
- Corner operands: M=−128, Q=−128 -> 0x4000; M=127, Q=−128 -> 0xC080; M=0, Q=−1 -> 0x0000; M=−1, Q=−1 -> 0x0001.
- Start pulsed mid-RUN with different operands -> ignored: Done timing and Product match the first operation only; Start held high through DONE -> next op accepted on the IDLE edge, one idle cycle between Done and Busy.
- Assert Rst_n=0 asynchronously at iteration 4 -> Busy, Done, Product go 0 immediately without a clock edge; after release, a new 3×5 yields 0x000F with normal latency.
- Randomized 1000 operand pairs vs. signed reference product, checking Done spacing and Busy/Done exclusivity every cycle.
